uart_duty_rx: RTL and testbench
===============================

Name: uart_duty_rx

Overview:
- Serial front end for the PWM stage: receives 8N1 UART bytes on a single line and holds the last good byte as the duty-cycle word that drives the PWM block's duty input.
- Sits directly upstream of the PWM generator in the same clock domain; its duty_o connects straight to the PWM duty input.
- Default timing is 10 MHz system clock and 9600 baud.

Parameters:
- WIDTH, 8, width of duty_o; must be >= 8; the received byte is zero-extended into the LSBs.
- CLKS_PER_BIT, 1042, system clocks per UART bit (10 MHz / 9600, rounded); must be >= 4.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- rx_i  input  1  asynchronous UART line; idle high.
- duty_o  output  WIDTH  last correctly framed byte, held until the next good byte.
- duty_valid_o  output  1  one-cycle pulse on the cycle duty_o takes a new value.
- frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low.
- busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high, sampled on the clk edge):
  - duty_o = 0 (PWM off); duty_valid_o, frame_err_o, busy_o = 0.
  - FSM = IDLE; bit counter and clock counter = 0; synchronizer flops = 1.
- Input synchronizer:
  - rx_i passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
  - Input latency is 2 cycles.
- State IDLE:
  - When rxs = 0, go to START and clear the clock counter.
- State START:
  - Count to CLKS_PER_BIT/2 - 1 (integer division), then sample rxs (mid start bit).
  - If rxs = 0: go to DATA; clear the clock counter and bit counter.
  - If rxs = 1: treat as a glitch and return to IDLE; no outputs change.
- State DATA:
  - Each time the clock counter reaches CLKS_PER_BIT - 1, sample rxs (mid-bit), shift it in LSB first, clear the clock counter and increment the bit counter.
  - After the 8th sample, go to STOP.
- State STOP:
  - After CLKS_PER_BIT clocks, sample rxs.
  - If rxs = 1: on the next edge duty_o = {zeros, byte}, duty_valid_o = 1 for exactly one cycle, FSM = IDLE.
  - If rxs = 0: frame_err_o = 1 for one cycle, duty_o unchanged, FSM = WAIT_IDLE.
- State WAIT_IDLE:
  - Stay until rxs = 1, then go to IDLE.
  - This prevents a break or a held-low line from being decoded as repeated 0x00 frames.
- Counter widths:
  - The clock counter is wide enough to hold CLKS_PER_BIT - 1.
  - The bit counter is 4 bits.
  - No counter wraps; each is explicitly cleared at the points above.
- Latency:
  - From the rx_i falling edge at the start of a frame to the duty_valid_o pulse: 2 + (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT + 1 cycles, +/- 1 for sampling phase.
- Back-to-back frames:
  - A start bit immediately following the stop bit (no idle gap) must be received.
  - After the stop sample, IDLE detects the next falling edge within the remaining half bit.
- Reset mid-frame:
  - Aborts the frame and clears duty_o to 0; the partial byte is discarded.
  - The next falling edge on rxs begins a fresh frame.
- Output rules:
  - duty_valid_o and frame_err_o are never high in the same cycle.
  - duty_o changes only on a duty_valid_o cycle or on reset.
  - busy_o is high from the START entry through the IDLE return, including WAIT_IDLE.

Test Plan:
- CLKS_PER_BIT = 16 for all scenarios.
- Single byte: send 0xA5 with a good stop bit -> duty_o = 0xA5, exactly one duty_valid_o pulse about 154 cycles after the start edge, frame_err_o stays 0.
- Glitch rejection: drive rx_i low for 4 cycles, then high -> FSM returns to IDLE, no duty_valid_o, duty_o unchanged, busy_o high for at most 8 cycles.
- Framing error:
  - Send 0x3C, with 0x11 previously latched, and hold the stop bit low for 40 cycles -> one frame_err_o pulse, duty_o stays 0x11.
  - busy_o stays high until rx_i returns high.
  - A following 0x22 frame is then received correctly.
- Back-to-back: send 0x00 then 0xFF with zero idle gap -> two duty_valid_o pulses, duty_o = 0x00 then 0xFF.
- Reset mid-frame: with duty_o = 0x55, assert rst_i for 1 cycle during data bit 4 -> duty_o = 0 and busy_o = 0 the next cycle; a subsequent 0x7E frame gives duty_o = 0x7E.
- Width extension: with WIDTH = 10, send 0xFF -> duty_o = 10'h0FF.

Source files
------------

// File: rtl/uart_duty_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_duty_rx
// Brief    : 8N1 UART receiver that holds the last correctly framed byte as
//            the duty-cycle word for the downstream PWM generator.
// Revision : 1.0 - initial release
// ============================================================================
module uart_duty_rx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             rx_i,
    output logic [WIDTH-1:0] duty_o,
    output logic             duty_valid_o,
    output logic             frame_err_o,
    output logic             busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    // Mid-start-bit and mid-data-bit sample points.
    localparam logic [CW-1:0] c_half_m1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_bit_m1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t           r_state, w_state_nx;
    logic [1:0]       r_sync;
    logic [CW-1:0]    r_clk_cnt, w_clk_cnt_nx;
    logic [3:0]       r_bit_cnt, w_bit_cnt_nx;
    logic [7:0]       r_shift, w_shift_nx;
    logic [WIDTH-1:0] r_duty, w_duty_nx;
    logic             r_valid, w_valid_nx;
    logic             r_ferr, w_ferr_nx;
    logic             w_rxs;

    assign w_rxs = r_sync[1];

    // Two-flop synchronizer for the asynchronous line, plus all FSM state.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_sync    <= 2'b11;
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_duty    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx_i};
            r_state   <= w_state_nx;
            r_clk_cnt <= w_clk_cnt_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_shift   <= w_shift_nx;
            r_duty    <= w_duty_nx;
            r_valid   <= w_valid_nx;
            r_ferr    <= w_ferr_nx;
        end
    end

    // Next-state logic: start detect, half-bit alignment, LSB-first shift,
    // stop-bit check; a low stop bit parks in WAIT_IDLE until the line idles.
    always_comb begin
        w_state_nx   = r_state;
        w_clk_cnt_nx = r_clk_cnt;
        w_bit_cnt_nx = r_bit_cnt;
        w_shift_nx   = r_shift;
        w_duty_nx    = r_duty;
        w_valid_nx   = 1'b0;
        w_ferr_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_nx   = S_START;
                    w_clk_cnt_nx = '0;
                end
            end
            S_START: begin
                if (r_clk_cnt == c_half_m1) begin
                    if (!w_rxs) begin
                        w_state_nx   = S_DATA;
                        w_clk_cnt_nx = '0;
                        w_bit_cnt_nx = '0;
                    end else begin
                        // Too short to be a start bit: treat as line noise.
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_clk_cnt == c_bit_m1) begin
                    w_shift_nx   = {w_rxs, r_shift[7:1]};
                    w_clk_cnt_nx = '0;
                    w_bit_cnt_nx = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_state_nx = S_STOP;
                    end
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_clk_cnt == c_bit_m1) begin
                    w_clk_cnt_nx = '0;
                    if (w_rxs) begin
                        w_duty_nx  = WIDTH'(r_shift);
                        w_valid_nx = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_ferr_nx  = 1'b1;
                        w_state_nx = S_WAIT_IDLE;
                    end
                end else begin
                    w_clk_cnt_nx = r_clk_cnt + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (w_rxs) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign duty_o       = r_duty;
    assign duty_valid_o = r_valid;
    assign frame_err_o  = r_ferr;
    assign busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_duty_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_duty_rx
// Brief    : Directed self-checking bench for uart_duty_rx (16 clocks/bit),
//            with a second 10-bit-wide instance sharing the same line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_duty_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i = 1'b1;
    logic [7:0] duty;
    logic [9:0] duty10;
    logic       valid, ferr, busy;
    logic       valid10, ferr10, busy10;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcount = 0;
    int fcount = 0;
    int busy_cnt = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    logic [7:0] vq[$];

    uart_duty_rx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) u_dut (
        .clk(clk), .rst_i(rst_i), .rx_i(rx_i), .duty_o(duty),
        .duty_valid_o(valid), .frame_err_o(ferr), .busy_o(busy)
    );

    uart_duty_rx #(.WIDTH(10), .CLKS_PER_BIT(CPB)) u_dut10 (
        .clk(clk), .rst_i(rst_i), .rx_i(rx_i), .duty_o(duty10),
        .duty_valid_o(valid10), .frame_err_o(ferr10), .busy_o(busy10)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output sampling on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (ferr) fcount++;
        if (valid) begin
            vcount++;
            valid_cyc = cyc;
            vq.push_back(duty);
        end
        if (valid || ferr) check("valid_ferr_exclusive", {31'd0, valid & ferr}, 32'd0);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        vcount = 0;
        fcount = 0;
        busy_cnt = 0;
        vq.delete();
    endtask

    // Start bit, 8 data bits LSB first, then stop level held for stop_cycles.
    // The line is left at stop_lvl afterwards.
    task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input int stop_cycles);
        @(negedge clk);
        rx_i = 1'b0;
        start_cyc = cyc;
        idle(CPB - 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_i = b[i];
            idle(CPB - 1);
        end
        @(negedge clk);
        rx_i = stop_lvl;
        idle(stop_cycles - 1);
    endtask

    initial begin
        // Reset state
        idle(3);
        check("reset_duty", {24'd0, duty}, 32'h00);
        check("reset_duty10", {22'd0, duty10}, 32'h000);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_ferr", {31'd0, ferr}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst_i = 1'b0;
        idle(20);

        // Single byte 0xA5
        clear_counts();
        send_byte(8'hA5, 1'b1, CPB);
        idle(20);
        check("a5_duty", {24'd0, duty}, 32'hA5);
        check("a5_valid_count", vcount, 1);
        check("a5_ferr_count", fcount, 0);
        check("a5_latency_in_window",
              {31'd0, ((valid_cyc - start_cyc) >= 153) && ((valid_cyc - start_cyc) <= 157)}, 32'd1);

        // Glitch rejection: 4 cycles low
        clear_counts();
        @(negedge clk);
        rx_i = 1'b0;
        idle(4);
        rx_i = 1'b1;
        idle(30);
        check("glitch_valid_count", vcount, 0);
        check("glitch_duty", {24'd0, duty}, 32'hA5);
        check("glitch_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
        check("glitch_busy_max8", {31'd0, busy_cnt <= 8}, 32'd1);
        check("glitch_busy_end", {31'd0, busy}, 32'd0);

        // Framing error with 0x11 latched
        send_byte(8'h11, 1'b1, CPB);
        idle(10);
        check("pre_ferr_duty", {24'd0, duty}, 32'h11);
        clear_counts();
        send_byte(8'h3C, 1'b0, 40);
        check("ferr_count", fcount, 1);
        check("ferr_valid_count", vcount, 0);
        check("ferr_duty_held", {24'd0, duty}, 32'h11);
        check("ferr_busy_while_low", {31'd0, busy}, 32'd1);
        rx_i = 1'b1;
        idle(10);
        check("ferr_busy_released", {31'd0, busy}, 32'd0);
        send_byte(8'h22, 1'b1, CPB);
        idle(10);
        check("after_ferr_duty", {24'd0, duty}, 32'h22);

        // Back-to-back 0x00 then 0xFF with no idle gap
        clear_counts();
        send_byte(8'h00, 1'b1, CPB);
        send_byte(8'hFF, 1'b1, CPB);
        idle(20);
        check("b2b_valid_count", vcount, 2);
        check("b2b_first", {24'd0, (vq.size() > 0) ? vq[0] : 8'hEE}, 32'h00);
        check("b2b_second", {24'd0, (vq.size() > 1) ? vq[1] : 8'hEE}, 32'hFF);
        check("b2b_ferr_count", fcount, 0);
        check("width10_duty", {22'd0, duty10}, 32'h0FF);

        // Reset during data bit 4 with 0x55 latched
        send_byte(8'h55, 1'b1, CPB);
        idle(10);
        check("pre_rst_duty", {24'd0, duty}, 32'h55);
        clear_counts();
        @(negedge clk);
        rx_i = 1'b0;
        idle(CPB - 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_i = 1'b1;
            idle(CPB - 1);
        end
        @(negedge clk);
        rx_i = 1'b1;
        idle(8);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("midrst_duty", {24'd0, duty}, 32'h00);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        idle(40);
        check("midrst_no_valid", vcount, 0);
        send_byte(8'h7E, 1'b1, CPB);
        idle(20);
        check("after_rst_duty", {24'd0, duty}, 32'h7E);
        check("after_rst_valid_count", vcount, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
